vs_omp_sequencer: RTL and testbench

Top-level iteration controller for the greedy sparse-recovery engine. Sequences the sensing-matrix processor (matrix load, batched inner products) and the max identifier (per-batch argmax), merges per-batch maxima into a global best atom, and records selected atoms in a support list. It runs for up to K iterations and stops early on a small correlation or a repeated atom.

---
 rtl/vs_omp_sequencer_pkg.sv | 43 ++++
 rtl/vs_support_tracker.sv | 44 ++++
 rtl/vs_omp_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_vs_omp_sequencer.sv | 527 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vs_omp_sequencer_pkg.sv
// Shared types for the sparse-recovery engine: matrix processor commands,
// sequencer stop reasons, FSM state encoding and the saturating magnitude helper.
package vs_omp_sequencer_pkg;

    typedef logic signed [31:0] fp_32_t;

    typedef enum logic [1:0] {
        COMPUTE_INNER_PRODUCTS = 2'd0,
        LOAD_SENSING_MATRIX    = 2'd1
    } vs_sensing_matrix_command_t;

    typedef enum logic [1:0] {
        K_REACHED    = 2'd0,
        BELOW_THRESH = 2'd1,
        REPEAT_ATOM  = 2'd2
    } vs_omp_stop_t;

    typedef logic [3:0] vs_omp_seq_state_t;

    localparam vs_omp_seq_state_t ST_IDLE       = 4'd0;
    localparam vs_omp_seq_state_t ST_LOAD_START = 4'd1;
    localparam vs_omp_seq_state_t ST_LOAD_WAIT  = 4'd2;
    localparam vs_omp_seq_state_t ST_IP_START   = 4'd3;
    localparam vs_omp_seq_state_t ST_IP_WAIT    = 4'd4;
    localparam vs_omp_seq_state_t ST_MAX_START  = 4'd5;
    localparam vs_omp_seq_state_t ST_MAX_WAIT   = 4'd6;
    localparam vs_omp_seq_state_t ST_SELECT     = 4'd7;
    localparam vs_omp_seq_state_t ST_COMMIT     = 4'd8;
    localparam vs_omp_seq_state_t ST_FINISH     = 4'd9;

    // 31-bit magnitude; the most negative value saturates instead of wrapping.
    function automatic logic [30:0] vs_abs31(input fp_32_t x);
        fp_32_t neg;
        neg = -x;
        if (!x[31])
            return x[30:0];
        else if (x == 32'sh8000_0000)
            return 31'h7FFF_FFFF;
        else
            return neg[30:0];
    endfunction

endpackage

// File: rtl/vs_support_tracker.sv
// Support list for the recovery run: K index slots with valid bits,
// a write port, a bulk clear and a parallel "already selected" match.
module vs_support_tracker
    import vs_omp_sequencer_pkg::*;
#(
    parameter int K  = 8,
    parameter int AW = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    idx,
    input  logic [7:0]    query,
    output logic          match
);

    logic [7:0]   idx_q [K];
    logic [K-1:0] valid_q;

    // Slot storage; clear only drops the valid bits, stale indices are harmless.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < K; i++)
                idx_q[i] <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else if (we) begin
            idx_q[addr]   <= idx;
            valid_q[addr] <= 1'b1;
        end
    end

    // Compare the query against every valid slot at once.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < K; i++)
            if (valid_q[i] && (idx_q[i] == query))
                match = 1'b1;
    end

endmodule

// File: rtl/vs_omp_sequencer.sv
// Iteration controller: drives the matrix processor and max identifier,
// merges per-batch maxima into a global best atom and commits it to the support.
module vs_omp_sequencer
    import vs_omp_sequencer_pkg::*;
#(
    parameter int     COLUMNS    = 256,
    parameter int     BATCH_SIZE = 64,
    parameter int     K          = 8,
    parameter fp_32_t THRESH     = '0
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 load_req,
    input  logic                                 run_req,
    output logic                                 busy,
    output logic                                 run_done,
    output logic [1:0]                           stop_reason,
    output logic [$clog2(K+1)-1:0]               iter_count,
    output vs_sensing_matrix_command_t           proc_command,
    output logic                                 proc_start,
    input  logic                                 proc_done,
    output logic                                 max_start,
    input  logic                                 max_batch_done,
    input  logic [7:0]                           max_location,
    input  logic [31:0]                          max_value,
    output logic                                 supp_we,
    output logic [((K > 1) ? $clog2(K) : 1)-1:0] supp_addr,
    output logic [7:0]                           supp_idx,
    output logic [31:0]                          supp_val
);

    localparam int BATCHES = COLUMNS / BATCH_SIZE;
    localparam int AW      = (K > 1) ? $clog2(K) : 1;
    localparam int CW      = $clog2(K + 1);
    localparam int BW      = (BATCHES > 1) ? $clog2(BATCHES) : 1;

    localparam logic [31:0]   THR    = THRESH;
    localparam logic [CW-1:0] K_LAST = CW'(K);
    localparam logic [BW-1:0] B_LAST = BW'(BATCHES - 1);

    vs_omp_seq_state_t state;
    logic [BW-1:0]     b;
    logic [30:0]       best_abs;
    logic [7:0]        best_idx;
    fp_32_t            best_val;

    logic [30:0]       cand_abs;
    logic [7:0]        cand_idx;
    logic [CW-1:0]     iter_next;
    logic              run_go;
    logic              trk_clear;
    logic              trk_we;
    logic              trk_match;

    assign cand_abs  = vs_abs31(max_value);
    assign cand_idx  = 8'(b) * 8'(BATCH_SIZE) + max_location;
    assign iter_next = iter_count + CW'(1);
    assign run_go    = (state == ST_IDLE) && run_req && !load_req;
    assign trk_clear = run_go;
    assign trk_we    = (state == ST_COMMIT);

    vs_support_tracker #(
        .K  (K),
        .AW (AW)
    ) u_tracker (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (trk_clear),
        .we      (trk_we),
        .addr    (iter_count[AW-1:0]),
        .idx     (best_idx),
        .query   (best_idx),
        .match   (trk_match)
    );

    // Main FSM; strobes default low so each is exactly one cycle wide.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            run_done     <= 1'b0;
            stop_reason  <= '0;
            iter_count   <= '0;
            proc_command <= COMPUTE_INNER_PRODUCTS;
            proc_start   <= 1'b0;
            max_start    <= 1'b0;
            supp_we      <= 1'b0;
            supp_addr    <= '0;
            supp_idx     <= '0;
            supp_val     <= '0;
            b            <= '0;
            best_abs     <= '0;
            best_idx     <= '0;
            best_val     <= '0;
        end else begin
            proc_start <= 1'b0;
            max_start  <= 1'b0;
            supp_we    <= 1'b0;
            run_done   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (load_req) begin
                        state <= ST_LOAD_START;
                        busy  <= 1'b1;
                    end else if (run_req) begin
                        state      <= ST_IP_START;
                        busy       <= 1'b1;
                        iter_count <= '0;
                    end
                end
                ST_LOAD_START: begin
                    proc_command <= LOAD_SENSING_MATRIX;
                    proc_start   <= 1'b1;
                    state        <= ST_LOAD_WAIT;
                end
                ST_LOAD_WAIT: begin
                    if (proc_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IP_START: begin
                    proc_command <= COMPUTE_INNER_PRODUCTS;
                    proc_start   <= 1'b1;
                    b            <= '0;
                    best_abs     <= '0;
                    best_idx     <= '0;
                    best_val     <= '0;
                    state        <= ST_IP_WAIT;
                end
                ST_IP_WAIT: begin
                    if (proc_done)
                        state <= ST_MAX_START;
                end
                ST_MAX_START: begin
                    max_start <= 1'b1;
                    state     <= ST_MAX_WAIT;
                end
                ST_MAX_WAIT: begin
                    if (max_batch_done) begin
                        if (cand_abs > best_abs) begin
                            best_abs <= cand_abs;
                            best_idx <= cand_idx;
                            best_val <= max_value;
                        end
                        if (b == B_LAST) begin
                            state <= ST_SELECT;
                        end else begin
                            b     <= b + BW'(1);
                            state <= ST_MAX_START;
                        end
                    end
                end
                ST_SELECT: begin
                    if ({1'b0, best_abs} <= THR) begin
                        stop_reason <= BELOW_THRESH;
                        run_done    <= 1'b1;
                        state       <= ST_FINISH;
                    end else if (trk_match) begin
                        stop_reason <= REPEAT_ATOM;
                        run_done    <= 1'b1;
                        state       <= ST_FINISH;
                    end else begin
                        supp_we   <= 1'b1;
                        supp_addr <= iter_count[AW-1:0];
                        supp_idx  <= best_idx;
                        supp_val  <= best_val;
                        state     <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    iter_count <= iter_next;
                    if (iter_next == K_LAST) begin
                        stop_reason <= K_REACHED;
                        run_done    <= 1'b1;
                        state       <= ST_FINISH;
                    end else begin
                        state <= ST_IP_START;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vs_omp_sequencer.sv
// Bench for vs_omp_sequencer: models the matrix processor and max identifier,
// and checks support writes and stop reasons against a plain OMP-selection model.
module tb_vs_omp_sequencer;
    import vs_omp_sequencer_pkg::*;

    localparam int     K      = 8;
    localparam int     NB     = 4;
    localparam int     BS     = 64;
    localparam longint THR    = 4;
    localparam longint MAXMAG = 64'h7FFF_FFFF;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic load_req = 1'b0;
    logic run_req = 1'b0;
    logic proc_done = 1'b0;
    logic max_done_r = 1'b0;
    logic spur = 1'b0;
    logic max_batch_done;
    logic [7:0] max_location = '0;
    logic [31:0] max_value = '0;

    logic busy, run_done, proc_start, max_start, supp_we;
    logic [1:0] stop_reason;
    logic [3:0] iter_count;
    logic [2:0] supp_addr;
    logic [7:0] supp_idx;
    logic [31:0] supp_val;
    vs_sensing_matrix_command_t proc_command;

    assign max_batch_done = max_done_r | spur;

    always #5 clock = ~clock;

    vs_omp_sequencer #(
        .COLUMNS    (256),
        .BATCH_SIZE (BS),
        .K          (K),
        .THRESH     (32'sd4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .load_req       (load_req),
        .run_req        (run_req),
        .busy           (busy),
        .run_done       (run_done),
        .stop_reason    (stop_reason),
        .iter_count     (iter_count),
        .proc_command   (proc_command),
        .proc_start     (proc_start),
        .proc_done      (proc_done),
        .max_start      (max_start),
        .max_batch_done (max_batch_done),
        .max_location   (max_location),
        .max_value      (max_value),
        .supp_we        (supp_we),
        .supp_addr      (supp_addr),
        .supp_idx       (supp_idx),
        .supp_val       (supp_val)
    );

    int errors = 0;
    int checks = 0;
    int unsigned tloc [K][NB];
    logic signed [31:0] tval [K][NB];
    int mcount = 0;
    int pstarts = 0;
    int done_cnt = 0;
    int wide_cnt = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int done_cyc = 0;
    int load_lat = 16384;
    int max_lat_lo = 1;
    int max_lat_hi = 5;
    bit spur_en = 0;
    int w_addr[$];
    int w_idx[$];
    logic [31:0] w_val[$];
    int exp_idx[$];
    logic [31:0] exp_val[$];

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Matrix processor model: one done pulse per start, with optional
    // stray max_batch_done early in the inner-product wait.
    initial begin
        int lat;
        forever begin
            @(negedge clock);
            if (proc_start === 1'b1) begin
                pstarts++;
                if (proc_command == LOAD_SENSING_MATRIX)
                    lat = load_lat;
                else
                    lat = $urandom_range(2, 6);
                for (int i = 0; i < lat; i++) begin
                    @(negedge clock);
                    spur = (spur_en && i == 0 &&
                            proc_command == COMPUTE_INNER_PRODUCTS);
                end
                spur = 1'b0;
                proc_done = 1'b1;
                @(negedge clock);
                proc_done = 1'b0;
            end
        end
    end

    // Max identifier model: returns the scripted maximum for each batch.
    initial begin
        int lat, it, bb;
        forever begin
            @(negedge clock);
            if (max_start === 1'b1) begin
                it = mcount / NB;
                bb = mcount % NB;
                mcount++;
                lat = $urandom_range(max_lat_lo, max_lat_hi);
                repeat (lat) @(negedge clock);
                max_location = (it < K) ? 8'(tloc[it][bb]) : 8'd0;
                max_value = (it < K) ? tval[it][bb] : 32'd0;
                max_done_r = 1'b1;
                @(negedge clock);
                max_done_r = 1'b0;
                max_location = 8'd0;
                max_value = 32'h7FFF_FFF0;
            end
        end
    end

    // Monitor: logs support writes, run_done pulses and over-wide strobes.
    initial begin
        bit pw, pp, pm, pr;
        pw = 0; pp = 0; pm = 0; pr = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (supp_we === 1'b1) begin
                w_addr.push_back(int'(supp_addr));
                w_idx.push_back(int'(supp_idx));
                w_val.push_back(supp_val);
                last_we_cyc = cyc;
            end
            if (run_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if ((supp_we && pw) || (proc_start && pp) ||
                (max_start && pm) || (run_done && pr))
                wide_cnt++;
            pw = supp_we; pp = proc_start; pm = max_start; pr = run_done;
        end
    end

    // Greedy selection straight from the rules: best |val| per iteration,
    // earliest index on ties, stop on threshold, repeat or K atoms.
    task automatic model_run(output int reason);
        longint a, babs;
        int bi;
        logic [31:0] bv;
        exp_idx.delete();
        exp_val.delete();
        reason = 0;
        for (int it = 0; it < K; it++) begin
            babs = 0; bi = 0; bv = 0;
            for (int bb = 0; bb < NB; bb++) begin
                a = longint'(tval[it][bb]);
                if (a < 0) a = -a;
                if (a > MAXMAG) a = MAXMAG;
                if (a > babs) begin
                    babs = a;
                    bi = bb * BS + int'(tloc[it][bb]);
                    bv = tval[it][bb];
                end
            end
            if (babs <= THR) begin reason = 1; return; end
            foreach (exp_idx[j])
                if (exp_idx[j] == bi) begin reason = 2; return; end
            exp_idx.push_back(bi);
            exp_val.push_back(bv);
            if (exp_idx.size() == K) begin reason = 0; return; end
        end
    endtask

    task automatic clear_log();
        w_addr.delete(); w_idx.delete(); w_val.delete();
        done_cnt = 0; wide_cnt = 0; mcount = 0; pstarts = 0;
    endtask

    task automatic do_run(output bit ok);
        clear_log();
        run_req = 1'b1; tick(1); run_req = 1'b0;
        ok = 0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            tick(1);
            if (done_cnt > 0) ok = 1;
        end
        tick(3);
    endtask

    task automatic fill_filler(input int from_it);
        for (int it = from_it; it < K; it++)
            for (int bb = 0; bb < NB; bb++) begin
                tloc[it][bb] = 5; tval[it][bb] = 1;
            end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        checks++;
        if ({busy, run_done, proc_start, max_start, supp_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 00000",
                     {busy, run_done, proc_start, max_start, supp_we});
        end
        checks++;
        if ({iter_count, stop_reason, supp_addr, supp_idx} !== '0 ||
            supp_val !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: iter=%0d reason=%0d addr=%0d idx=%0d val=%0h want all 0",
                     iter_count, stop_reason, supp_addr, supp_idx, supp_val);
        end
        checks++;
        if (proc_command !== COMPUTE_INNER_PRODUCTS) begin
            errors++;
            $display("FAIL reset_cmd: got %0d want %0d",
                     proc_command, COMPUTE_INNER_PRODUCTS);
        end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_load();
        int c0, elapsed;
        bit idle;
        clear_log();
        load_lat = 16384;
        c0 = cyc;
        load_req = 1'b1; tick(1); load_req = 1'b0;
        tick(3);
        checks++;
        if (proc_command !== LOAD_SENSING_MATRIX || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_cmd: cmd=%0d busy=%b want cmd=%0d busy=1",
                     proc_command, busy, LOAD_SENSING_MATRIX);
        end
        run_req = 1'b1; tick(1); run_req = 1'b0;
        idle = 0;
        for (int i = 0; i < 17000 && !idle; i++) begin
            tick(1);
            if (busy === 1'b0) idle = 1;
        end
        elapsed = cyc - c0;
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL load_timeout: busy=%b want 0", busy);
        end
        checks++;
        if (elapsed < 16384) begin
            errors++;
            $display("FAIL load_latency: got %0d cycles want >= 16384", elapsed);
        end
        checks++;
        if (pstarts !== 1 || done_cnt !== 0 || wide_cnt !== 0) begin
            errors++;
            $display("FAIL load_pulses: starts=%0d run_done=%0d wide=%0d want 1 0 0",
                     pstarts, done_cnt, wide_cnt);
        end
        tick(5);
    endtask

    task automatic test_both_req();
        bit idle;
        clear_log();
        load_lat = 4;
        load_req = 1'b1; run_req = 1'b1; tick(1);
        load_req = 1'b0; run_req = 1'b0;
        tick(2);
        checks++;
        if (proc_command !== LOAD_SENSING_MATRIX) begin
            errors++;
            $display("FAIL both_req_cmd: got %0d want %0d",
                     proc_command, LOAD_SENSING_MATRIX);
        end
        idle = 0;
        for (int i = 0; i < 100 && !idle; i++) begin
            tick(1);
            if (busy === 1'b0) idle = 1;
        end
        tick(5);
        checks++;
        if (!idle || pstarts !== 1 || done_cnt !== 0 || w_idx.size() !== 0) begin
            errors++;
            $display("FAIL both_req: idle=%b starts=%0d run_done=%0d writes=%0d want 1 1 0 0",
                     idle, pstarts, done_cnt, w_idx.size());
        end
    endtask

    task automatic test_argmax();
        bit ok;
        int locs[NB] = '{3, 10, 0, 63};
        int vals[NB] = '{5, -9, 9, 2};
        fill_filler(2);
        for (int it = 0; it < 2; it++)
            for (int bb = 0; bb < NB; bb++) begin
                tloc[it][bb] = locs[bb]; tval[it][bb] = vals[bb];
            end
        do_run(ok);
        checks++;
        if (!ok || done_cnt !== 1) begin
            errors++;
            $display("FAIL argmax_done: ok=%b run_done=%0d want 1 1", ok, done_cnt);
        end
        checks++;
        if (w_idx.size() !== 1) begin
            errors++;
            $display("FAIL argmax_writes: got %0d want 1", w_idx.size());
        end else if (w_idx[0] !== 74 || w_val[0] !== 32'hFFFF_FFF7 ||
                     w_addr[0] !== 0) begin
            errors++;
            $display("FAIL argmax_entry: addr=%0d idx=%0d val=%0h want 0 74 fffffff7",
                     w_addr[0], w_idx[0], w_val[0]);
        end
        checks++;
        if (stop_reason !== 2'd2 || iter_count !== 4'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL argmax_end: reason=%0d iter=%0d busy=%b want 2 1 0",
                     stop_reason, iter_count, busy);
        end
    endtask

    task automatic test_threshold();
        bit ok;
        int vals[NB] = '{4, -4, 0, 3};
        for (int it = 0; it < K; it++)
            for (int bb = 0; bb < NB; bb++) begin
                tloc[it][bb] = $urandom_range(0, 63);
                tval[it][bb] = vals[(bb + it) % NB];
            end
        do_run(ok);
        checks++;
        if (!ok || done_cnt !== 1 || w_idx.size() !== 0) begin
            errors++;
            $display("FAIL thresh_run: ok=%b run_done=%0d writes=%0d want 1 1 0",
                     ok, done_cnt, w_idx.size());
        end
        checks++;
        if (stop_reason !== 2'd1 || iter_count !== 4'd0) begin
            errors++;
            $display("FAIL thresh_end: reason=%0d iter=%0d want 1 0",
                     stop_reason, iter_count);
        end
    endtask

    task automatic test_repeat();
        bit ok;
        fill_filler(0);
        tloc[0][0] = 17; tval[0][0] = 50;
        tloc[1][0] = 17; tval[1][0] = -60;
        do_run(ok);
        checks++;
        if (!ok || done_cnt !== 1 || w_idx.size() !== 1) begin
            errors++;
            $display("FAIL repeat_run: ok=%b run_done=%0d writes=%0d want 1 1 1",
                     ok, done_cnt, w_idx.size());
        end else if (w_addr[0] !== 0 || w_idx[0] !== 17 || w_val[0] !== 32'd50) begin
            errors++;
            $display("FAIL repeat_entry: addr=%0d idx=%0d val=%0d want 0 17 50",
                     w_addr[0], w_idx[0], w_val[0]);
        end
        checks++;
        if (stop_reason !== 2'd2 || iter_count !== 4'd1) begin
            errors++;
            $display("FAIL repeat_end: reason=%0d iter=%0d want 2 1",
                     stop_reason, iter_count);
        end
    endtask

    task automatic fill_distinct();
        for (int it = 0; it < K; it++)
            for (int bb = 0; bb < NB; bb++) begin
                tloc[it][bb] = (bb == it % NB) ? it : 40;
                tval[it][bb] = (bb == it % NB) ? 100 + it : 1;
            end
    endtask

    task automatic test_reset_mid();
        bit hit, ok;
        fill_distinct();
        clear_log();
        max_lat_lo = 6; max_lat_hi = 8;
        run_req = 1'b1; tick(1); run_req = 1'b0;
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick(1);
            if (mcount >= NB + 2) hit = 1;
        end
        tick(2);
        checks++;
        if (!hit || iter_count !== 4'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_setup: reached=%b iter=%0d busy=%b want 1 1 1",
                     hit, iter_count, busy);
        end
        reset_n = 1'b0; tick(1);
        checks++;
        if ({busy, run_done, proc_start, max_start, supp_we} !== 5'b0 ||
            iter_count !== 4'd0 || stop_reason !== 2'd0) begin
            errors++;
            $display("FAIL midrun_reset: strobes=%b iter=%0d reason=%0d want 00000 0 0",
                     {busy, run_done, proc_start, max_start, supp_we},
                     iter_count, stop_reason);
        end
        reset_n = 1'b1;
        max_lat_lo = 1; max_lat_hi = 5;
        tick(25);
        do_run(ok);
        checks++;
        if (!ok || done_cnt !== 1 || w_idx.size() !== K ||
            stop_reason !== 2'd0 || iter_count !== 4'd8) begin
            errors++;
            $display("FAIL midrun_rerun: ok=%b done=%0d writes=%0d reason=%0d iter=%0d want 1 1 8 0 8",
                     ok, done_cnt, w_idx.size(), stop_reason, iter_count);
        end
    endtask

    task automatic test_full_run();
        bit ok;
        int bad;
        fill_distinct();
        spur_en = 1;
        do_run(ok);
        spur_en = 0;
        bad = 0;
        foreach (w_idx[i])
            if (w_addr[i] != i || w_idx[i] != (i % NB) * BS + i ||
                w_val[i] != 32'(100 + i))
                bad++;
        checks++;
        if (!ok || w_idx.size() !== K || bad !== 0) begin
            errors++;
            $display("FAIL full_writes: ok=%b writes=%0d bad=%0d want 1 8 0",
                     ok, w_idx.size(), bad);
        end
        checks++;
        if (stop_reason !== 2'd0 || iter_count !== 4'd8 ||
            done_cnt !== 1 || wide_cnt !== 0) begin
            errors++;
            $display("FAIL full_end: reason=%0d iter=%0d done=%0d wide=%0d want 0 8 1 0",
                     stop_reason, iter_count, done_cnt, wide_cnt);
        end
        checks++;
        if (done_cyc - last_we_cyc !== 1) begin
            errors++;
            $display("FAIL full_done_lag: got %0d want 1", done_cyc - last_we_cyc);
        end
    endtask

    task automatic test_random();
        bit ok;
        int mode, r, reason, bad;
        for (int run = 0; run < 16; run++) begin
            mode = $urandom_range(0, 2);
            for (int it = 0; it < K; it++)
                for (int bb = 0; bb < NB; bb++) begin
                    r = $urandom_range(0, 3);
                    unique case (mode)
                        0: begin
                            tloc[it][bb] = $urandom_range(0, 63);
                            tval[it][bb] = (r == 0) ? 32'h8000_0000 :
                                           (r == 1) ? 32'h7FFF_FFFF : $urandom;
                        end
                        1: begin
                            tloc[it][bb] = $urandom_range(0, 3);
                            tval[it][bb] = int'($urandom_range(0, 24)) - 12;
                        end
                        default: begin
                            tloc[it][bb] = $urandom_range(0, 63);
                            tval[it][bb] = int'($urandom_range(0, 9)) - 4;
                        end
                    endcase
                end
            model_run(reason);
            do_run(ok);
            bad = 0;
            foreach (w_idx[i])
                if (i >= exp_idx.size() || w_addr[i] != i ||
                    w_idx[i] != exp_idx[i] || w_val[i] != exp_val[i])
                    bad++;
            checks++;
            if (!ok || w_idx.size() !== exp_idx.size() || bad !== 0) begin
                errors++;
                $display("FAIL rand%0d_writes: ok=%b writes=%0d bad=%0d want 1 %0d 0",
                         run, ok, w_idx.size(), bad, exp_idx.size());
            end
            checks++;
            if (int'(stop_reason) !== reason ||
                int'(iter_count) !== exp_idx.size() ||
                done_cnt !== 1 || wide_cnt !== 0) begin
                errors++;
                $display("FAIL rand%0d_end: reason=%0d iter=%0d done=%0d wide=%0d want %0d %0d 1 0",
                         run, stop_reason, iter_count, done_cnt, wide_cnt,
                         reason, exp_idx.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_both_req();
        test_argmax();
        test_threshold();
        test_repeat();
        test_reset_mid();
        test_full_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
